// File: rtl/hazard_unit_sb_pkg.sv
// hazard_pkg: shared constants and helpers for the hazard unit slice.
//   FWD_RF / FWD_WB / FWD_MEM : E-stage forwarding select encodings
//   cnt_width()               : width of the MDU countdown for a latency
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Countdown must hold the value MDU_LAT itself, hence lat+1 states.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_sb_if.sv
// hazard_unit_sb_if: bundle of pipeline-side signals seen by the hazard unit.
//   slave  modport : hazard unit side (reads pipeline state, drives controls)
//   master modport : pipeline side (drives pipeline state, reads controls)
// Signals keep the pipeline's established names (RsD, WriteRegM, ...).
interface hazard_unit_sb_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 16
);
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE;
  logic [REG_AW-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic              MemtoRegE, MemtoRegM;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              BranchD, PCSrcD;
  logic              MduOpD, MduStartE;
  logic [REG_AW-1:0] MduDstE;
  logic              PerfClr;

  logic              StallF, StallD, FlushE, FlushD;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD;
  logic              MduBusy, MduDoneW, MduErr;
  logic [REG_AW-1:0] MduDstW;
  logic [PERF_W-1:0] StallCount;

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           MemtoRegE, MemtoRegM, RegWriteE, RegWriteM, RegWriteW,
           BranchD, PCSrcD, MduOpD, MduStartE, MduDstE, PerfClr,
    output StallF, StallD, FlushE, FlushD, ForwardAE, ForwardBE,
           ForwardAD, ForwardBD, MduBusy, MduDoneW, MduDstW, MduErr,
           StallCount
  );

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           MemtoRegE, MemtoRegM, RegWriteE, RegWriteM, RegWriteW,
           BranchD, PCSrcD, MduOpD, MduStartE, MduDstE, PerfClr,
    input  StallF, StallD, FlushE, FlushD, ForwardAE, ForwardBE,
           ForwardAD, ForwardBD, MduBusy, MduDoneW, MduDstW, MduErr,
           StallCount
  );
endinterface

// File: rtl/hazard_unit_sb_mdu_scoreboard.sv
// mdu_scoreboard: tracks the single outstanding fixed-latency MDU operation.
//   clk, rst : clock, async active-high reset
//   start    : MDU op issuing from E
//   dst_in   : destination register of the issuing op
//   busy     : an op is in flight (countdown non-zero)
//   dst      : destination of the op in flight (last accepted op)
//   done     : one-cycle writeback pulse when the countdown expires
//   dst_w    : register written back alongside done
//   err      : sticky flag, set by an issue attempt while busy
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REG_AW-1:0] dst_in,
  output logic              busy,
  output logic [REG_AW-1:0] dst,
  output logic              done,
  output logic [REG_AW-1:0] dst_w,
  output logic              err
);

  localparam int CNT_W = cnt_width(MDU_LAT);

  logic [CNT_W-1:0] cnt;

  // Countdown from MDU_LAT; the 1->0 step produces the writeback pulse.
  // An issue while counting is dropped and latched as a protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      dst   <= '0;
      done  <= 1'b0;
      dst_w <= '0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          done  <= 1'b1;
          dst_w <= dst;
        end
        if (start)
          err <= 1'b1;
      end else if (start) begin
        cnt <= CNT_W'(MDU_LAT);
        dst <= dst_in;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: hazard unit for the 5-stage MIPS core with MDU scoreboard.
//   clk, rst : clock, async active-high reset
//   hz       : hazard_unit_sb_if.slave carrying pipeline register numbers,
//              write enables, branch/MDU status and PerfClr in; stall/flush,
//              forwarding selects, MDU status and StallCount out
// Parameters: REG_AW address width, MDU_LAT MDU latency (>=1), PERF_W stall
// counter width, BR_FWD_EN enables forwarding into the D-stage comparator.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int MDU_LAT   = 4,
  parameter int PERF_W    = 16,
  parameter int BR_FWD_EN = 1
) (
  input  logic clk,
  input  logic rst,
  hazard_unit_sb_if.slave hz
);

  localparam bit BRF = (BR_FWD_EN != 0);

  logic              lwstall, branchstall, mduhaz, stall;
  logic              e_hits_d, m_hits_d;
  logic              mdu_busy;
  logic [REG_AW-1:0] mdu_dst;
  logic [PERF_W-1:0] perf_cnt;

  mdu_scoreboard #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .start  (hz.MduStartE),
    .dst_in (hz.MduDstE),
    .busy   (mdu_busy),
    .dst    (mdu_dst),
    .done   (hz.MduDoneW),
    .dst_w  (hz.MduDstW),
    .err    (hz.MduErr)
  );

  // M has priority over W because it holds the younger result.
  assign hz.ForwardAE = (hz.RsE != '0 && hz.RsE == hz.WriteRegM && hz.RegWriteM) ? FWD_MEM :
                        (hz.RsE != '0 && hz.RsE == hz.WriteRegW && hz.RegWriteW) ? FWD_WB  :
                                                                                   FWD_RF;
  assign hz.ForwardBE = (hz.RtE != '0 && hz.RtE == hz.WriteRegM && hz.RegWriteM) ? FWD_MEM :
                        (hz.RtE != '0 && hz.RtE == hz.WriteRegW && hz.RegWriteW) ? FWD_WB  :
                                                                                   FWD_RF;

  assign hz.ForwardAD = BRF && hz.RsD != '0 && hz.RsD == hz.WriteRegM && hz.RegWriteM;
  assign hz.ForwardBD = BRF && hz.RtD != '0 && hz.RtD == hz.WriteRegM && hz.RegWriteM;

  assign lwstall = hz.MemtoRegE && hz.RtE != '0 && (hz.RsD == hz.RtE || hz.RtD == hz.RtE);

  // A D-stage source matches the E or M destination register.
  assign e_hits_d = hz.WriteRegE != '0 && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD);
  assign m_hits_d = hz.WriteRegM != '0 && (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD);

  // Without branch forwarding any pending ALU result in M must also be waited out.
  assign branchstall = hz.BranchD && ((hz.RegWriteE && e_hits_d) ||
                                      (hz.MemtoRegM && m_hits_d) ||
                                      (!BRF && hz.RegWriteM && m_hits_d));

  // RAW on the in-flight MDU destination, or a second MDU op (structural).
  assign mduhaz = mdu_busy && ((hz.RsD != '0 && hz.RsD == mdu_dst) ||
                               (hz.RtD != '0 && hz.RtD == mdu_dst) ||
                               hz.MduOpD);

  assign stall     = lwstall | branchstall | mduhaz;
  assign hz.StallF = stall;
  assign hz.StallD = stall;
  assign hz.FlushE = stall;
  assign hz.FlushD = hz.PCSrcD && !stall;
  assign hz.MduBusy = mdu_busy;

  // Stall-cycle counter: clear wins over count, and it sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_cnt <= '0;
    else if (hz.PerfClr)
      perf_cnt <= '0;
    else if (stall && perf_cnt != '1)
      perf_cnt <= perf_cnt + 1'b1;
  end

  assign hz.StallCount = perf_cnt;

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
- Parametrised successor to the pipeline hazard unit for the 5-stage MIPS core.
- Keeps the existing functions: E-stage and D-stage forwarding, load-use stall and branch-compare stall.
- Adds a sequential scoreboard for a fixed-latency multiply/divide unit (MDU), a taken-branch D flush, a forwarding mode switch, and a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5: register-address width.
- MDU_LAT, 4: MDU result latency in cycles after issue; must be at least 1.
- PERF_W, 16: width of the stall-cycle counter.
- BR_FWD_EN, 1: 1 enables D-stage branch forwarding. 0 forces ForwardAD/BD to 0 and stalls the branch on any matching ALU result in M.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- RsD, RtD, RsE, RtE  in  REG_AW  source registers in D and E.
- WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination registers.
- MemtoRegE, MemtoRegM  in  1  load in E / M.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables.
- BranchD  in  1  branch in D.
- PCSrcD  in  1  branch taken in D.
- MduOpD  in  1  D instruction is an MDU op.
- MduStartE  in  1  MDU op in E (issue).
- MduDstE  in  REG_AW  MDU destination.
- PerfClr  in  1  synchronous counter clear.
- StallF, StallD, FlushE, FlushD  out  1  pipeline control.
- ForwardAE, ForwardBE  out  2  E-stage forwarding select.
- ForwardAD, ForwardBD  out  1  D-stage forwarding select.
- MduBusy  out  1  MDU op outstanding.
- MduDoneW  out  1  one-cycle MDU writeback pulse.
- MduDstW  out  REG_AW  MDU writeback register.
- MduErr  out  1  sticky protocol error.
- StallCount  out  PERF_W  stall cycles.

Behaviour:
- Clock and reset: one clock `clk`, posedge; `rst` asynchronous, active-high.
- Reset values: all registered state cleared, so MduBusy=0, MduDoneW=0, MduDstW=0, MduErr=0, StallCount=0. Reset mid-MDU-op abandons the op with no done pulse.
- ForwardAE, combinational, by priority:
  - 2'b10 if RsE!=0, RsE==WriteRegM and RegWriteM.
  - else 2'b01 if RsE!=0, RsE==WriteRegW and RegWriteW.
  - else 2'b00.
- ForwardBE: same rule using RtE.
- ForwardAD = BR_FWD_EN && RsD!=0 && RsD==WriteRegM && RegWriteM. ForwardBD is the same with RtD.
- lwstall = MemtoRegE && RtE!=0 && (RsD==RtE || RtD==RtE).
- branchstall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM∈{RsD,RtD})).
- When BR_FWD_EN=0, branchstall additionally includes BranchD && RegWriteM && WriteRegM!=0 && WriteRegM∈{RsD,RtD}.
- MDU scoreboard, registered countdown `cnt` of width clog2(MDU_LAT+1):
  - Accept: MduStartE && cnt==0 → cnt<=MDU_LAT, dst<=MduDstE.
  - Each cycle with cnt!=0: cnt<=cnt-1.
  - MduBusy = (cnt!=0), high for exactly MDU_LAT cycles after the accept edge.
  - On the edge where cnt goes 1→0, MduDoneW<=1 for one cycle and MduDstW<=dst.
  - The register file writes in the first half-cycle, so the done cycle carries no hazard.
  - MduStartE while cnt!=0 is ignored and sets MduErr, which stays set until rst.
- mduhaz = MduBusy && ((RsD!=0 && RsD==dst) || (RtD!=0 && RtD==dst) || MduOpD). This covers the RAW hazard and the structural hazard.
- Stall outputs: stall = lwstall | branchstall | mduhaz; StallF = StallD = FlushE = stall.
- FlushD = PCSrcD && !stall. A stalled branch never flushes.
- StallCount:
  - PerfClr → 0, taking priority over increment.
  - else stall → +1, saturating at all-ones.
- All outputs except the registered ones listed above are combinational from the current inputs.

Decomposition:
- Package hazard_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Function for the counter width, clog2(MDU_LAT+1).
- Sub-module mdu_scoreboard:
  - Contains cnt, dst, the done pulse and MduErr.
  - Inputs: clk, rst, start, dst_in.
  - Outputs: busy, dst, done, err.
- hazard_unit_sb instantiates mdu_scoreboard and holds the combinational forwarding and stall logic plus the perf counter.

Test Plan:
- EX forwarding: RsE=3, RegWriteM=1, WriteRegM=3, RegWriteW=1, WriteRegW=3 → ForwardAE=2'b10, M wins. With RsE=0 and the same matches → ForwardAE=2'b00.
- Load-use: MemtoRegE=1, RtE=5, RsD=5 → StallF=StallD=FlushE=1 for that cycle, StallCount+1. Same with RtE=0 → no stall.
- Branch mode: BranchD=1, RsD=7, RegWriteM=1, WriteRegM=7, MemtoRegM=0 → BR_FWD_EN=1: ForwardAD=1, no stall; BR_FWD_EN=0: ForwardAD=0, stall=1. With PCSrcD=1 and no stall → FlushD=1.
- MDU timing: MDU_LAT=4; MduStartE=1, MduDstE=9 for one cycle → MduBusy high 4 cycles. RsD=9 stalls each busy cycle and releases in the MduDoneW cycle, where MduDoneW=1 and MduDstW=9. MduOpD while busy also stalls.
- Errors/reset: second MduStartE while busy → ignored, MduErr=1 sticky. rst mid-count → MduBusy=0, no MduDoneW, MduErr=0, StallCount=0.
- Perf counter: PERF_W=4, stall held 20 cycles → StallCount=15 saturated. PerfClr with stall=1 → 0.
